// File: rtl/mx_vector_unpacker.sv
// mx_vector_unpacker: accepts one packed MX vector (8-bit shared scale plus
// BLOCK_SIZE elements in a runtime-selected format) and streams its elements
// LANES per beat, right-aligned in 8-bit lanes with zero/special flags.
module mx_vector_unpacker #(
    parameter int BLOCK_SIZE = 32,
    parameter int LANES      = 4,
    parameter int IN_W       = 8 + 8*BLOCK_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [IN_W-1:0]      in_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_elem,
    output logic [LANES-1:0]     out_zero,
    output logic [LANES-1:0]     out_special,
    output logic [7:0]           out_scale,
    output logic                 out_scale_nan,
    output logic [2:0]           out_fmt,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 err_fmt
);

    localparam int NBEATS = BLOCK_SIZE / LANES;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    localparam logic [2:0] FMT_E5M2 = 3'd0;
    localparam logic [2:0] FMT_E4M3 = 3'd1;
    localparam logic [2:0] FMT_E3M2 = 3'd2;
    localparam logic [2:0] FMT_E2M3 = 3'd3;
    localparam logic [2:0] FMT_E2M1 = 3'd4;
    localparam logic [2:0] FMT_INT8 = 3'd5;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   vec_q, vec_d;
    logic [2:0]        fmt_q, fmt_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              err_q, err_d;

    logic              fmt_legal;
    logic              is_last;
    logic              stream_act;

    assign fmt_legal  = (in_fmt <= FMT_INT8);
    assign is_last    = (beat_q == LAST_BEAT);
    assign stream_act = (state_q == ST_STREAM);

    // State, buffer, format, beat counter and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            fmt_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            fmt_q   <= fmt_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic and handshake outputs; a legal vector accepted on the
    // last beat reloads the buffer so back-to-back vectors have no bubble
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        fmt_d     = fmt_q;
        beat_d    = beat_q;
        err_d     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (fmt_legal) begin
                        vec_d   = in_vec;
                        fmt_d   = in_fmt;
                        beat_d  = '0;
                        state_d = ST_STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (is_last) begin
                        in_ready = 1'b1;
                        if (in_valid && fmt_legal) begin
                            vec_d  = in_vec;
                            fmt_d  = in_fmt;
                            beat_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                            err_d   = in_valid;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-lane element extraction and classification
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        int          idx;
        int          eb;
        logic [7:0]  mask;
        logic [7:0]  raw;
        logic        is_zero;
        logic        is_special;

        // Select the lane's EB-bit field for the current beat and flag it
        always_comb begin
            case (fmt_q)
                FMT_E3M2, FMT_E2M3: begin eb = 6; mask = 8'h3F; end
                FMT_E2M1:           begin eb = 4; mask = 8'h0F; end
                default:            begin eb = 8; mask = 8'hFF; end
            endcase
            idx = int'(beat_q) * LANES + gi;
            raw = 8'(vec_q >> (idx * eb)) & mask;
            // Signed zero: only the sign bit (field MSB) may be set; INT8 has a single zero
            if (fmt_q == FMT_INT8) begin
                is_zero = (raw == 8'h00);
            end else begin
                is_zero = ((raw & (mask >> 1)) == 8'h00);
            end
            case (fmt_q)
                FMT_E5M2: is_special = (raw[6:2] == 5'h1F);
                FMT_E4M3: is_special = (raw[6:0] == 7'h7F);
                default:  is_special = 1'b0;
            endcase
        end

        assign out_elem[gi*8 +: 8] = stream_act ? raw : 8'h00;
        assign out_zero[gi]        = stream_act && is_zero;
        assign out_special[gi]     = stream_act && is_special;
    end

    assign out_scale     = stream_act ? vec_q[IN_W-1 -: 8] : 8'h00;
    assign out_scale_nan = stream_act && (vec_q[IN_W-1 -: 8] == 8'hFF);
    assign out_fmt       = stream_act ? fmt_q : 3'd0;
    assign out_first     = stream_act && (beat_q == '0);
    assign out_last      = stream_act && is_last;
    assign err_fmt       = err_q;

endmodule

// File: tb/tb_mx_vector_unpacker.sv
// Directed self-checking bench for mx_vector_unpacker (BLOCK_SIZE=32, LANES=4).
module tb_mx_vector_unpacker;

    localparam int IN_W = 264;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [IN_W-1:0]   in_vec;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_elem;
    logic [3:0]        out_zero;
    logic [3:0]        out_special;
    logic [7:0]        out_scale;
    logic              out_scale_nan;
    logic [2:0]        out_fmt;
    logic              out_first;
    logic              out_last;
    logic              err_fmt;

    int n_checks = 0;
    int n_errors = 0;

    mx_vector_unpacker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_fmt        (in_fmt),
        .in_vec        (in_vec),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_elem      (out_elem),
        .out_zero      (out_zero),
        .out_special   (out_special),
        .out_scale     (out_scale),
        .out_scale_nan (out_scale_nan),
        .out_fmt       (out_fmt),
        .out_first     (out_first),
        .out_last      (out_last),
        .err_fmt       (err_fmt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [31:0] elem, input logic [3:0] zero,
                              input logic [3:0] spec, input logic [7:0] scale, input bit nan,
                              input logic [2:0] fmt, input bit first, input bit last);
        check_eq({tag, ".valid"},   out_valid,     1);
        check_eq({tag, ".elem"},    out_elem,      elem);
        check_eq({tag, ".zero"},    out_zero,      zero);
        check_eq({tag, ".special"}, out_special,   spec);
        check_eq({tag, ".scale"},   out_scale,     scale);
        check_eq({tag, ".nan"},     out_scale_nan, nan);
        check_eq({tag, ".fmt"},     out_fmt,       fmt);
        check_eq({tag, ".first"},   out_first,     first);
        check_eq({tag, ".last"},    out_last,      last);
        $display("beat %s elem=%08h zero=%b special=%b first=%0b last=%0b",
                 tag, out_elem, out_zero, out_special, out_first, out_last);
    endtask

    // Element k = ramp ? k : (k even ? e0 : e1); bits above the element area set to 1
    function automatic logic [IN_W-1:0] pack_vec(input logic [2:0] fmt, input logic [7:0] scale,
                                                 input logic [7:0] e0, input logic [7:0] e1,
                                                 input bit ramp);
        logic [IN_W-1:0] v;
        logic [7:0]      e;
        int              eb;
        case (fmt)
            3'd2, 3'd3: eb = 6;
            3'd4:       eb = 4;
            default:    eb = 8;
        endcase
        v = '0;
        for (int k = 0; k < 32; k++) begin
            e = ramp ? 8'(k) : (((k % 2) == 0) ? e0 : e1);
            for (int i = 0; i < eb; i++) v[k*eb + i] = e[i];
        end
        for (int i = 32*eb; i < 256; i++) v[i] = 1'b1;
        v[263:256] = scale;
        return v;
    endfunction

    function automatic logic [31:0] ramp_word(input int b);
        int k;
        k = 4 * b;
        return {8'(k + 3), 8'(k + 2), 8'(k + 1), 8'(k)};
    endfunction

    initial begin
        int beat;
        int cyc;

        rst_n = 1'b0; in_valid = 1'b0; in_fmt = 3'd0; in_vec = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst.out_valid", out_valid, 0);
        check_eq("rst.err_fmt",   err_fmt,   0);
        check_eq("rst.out_elem",  out_elem,  0);
        check_eq("rst.out_zero",  out_zero,  0);
        check_eq("rst.out_first", out_first, 0);
        check_eq("rst.out_last",  out_last,  0);
        check_eq("rst.out_scale", out_scale, 0);
        check_eq("rst.out_nan",   out_scale_nan, 0);
        rst_n = 1'b1;
        #1;
        check_eq("rst.in_ready", in_ready, 1);
        $display("reset done");

        // INT8 ramp, scale 7F
        in_valid = 1'b1; in_fmt = 3'd5; in_vec = pack_vec(3'd5, 8'h7F, 8'h00, 8'h00, 1'b1);
        @(negedge clk); in_valid = 1'b0; #1;
        for (int b = 0; b < 8; b++) begin
            check_beat("int8", ramp_word(b), (b == 0) ? 4'b0001 : 4'b0000, 4'b0000,
                       8'h7F, 1'b0, 3'd5, b == 0, b == 7);
            check_eq("int8.in_ready", in_ready, b == 7);
            @(negedge clk); in_valid = 1'b0; #1;
        end
        check_eq("int8.done", out_valid, 0);

        // FP4 all-F followed without a gap by E5M2 7C
        in_valid = 1'b1; in_fmt = 3'd4; in_vec = pack_vec(3'd4, 8'h01, 8'h0F, 8'h0F, 1'b0);
        @(negedge clk); in_valid = 1'b0; #1;
        for (int b = 0; b < 8; b++) begin
            check_beat("fp4", 32'h0F0F0F0F, 4'b0000, 4'b0000, 8'h01, 1'b0, 3'd4, b == 0, b == 7);
            if (b == 7) begin
                in_valid = 1'b1; in_fmt = 3'd0; in_vec = pack_vec(3'd0, 8'h02, 8'h7C, 8'h7C, 1'b0);
                #1;
                check_eq("fp4.in_ready_last", in_ready, 1);
            end
            @(negedge clk); in_valid = 1'b0; #1;
        end
        for (int b = 0; b < 8; b++) begin
            check_beat("e5m2", 32'h7C7C7C7C, 4'b0000, 4'b1111, 8'h02, 1'b0, 3'd0, b == 0, b == 7);
            @(negedge clk); in_valid = 1'b0; #1;
        end
        check_eq("e5m2.done", out_valid, 0);

        // E4M3 alternating 7F/80 with NaN scale; illegal vector on last beat ends stream
        in_valid = 1'b1; in_fmt = 3'd1; in_vec = pack_vec(3'd1, 8'hFF, 8'h7F, 8'h80, 1'b0);
        @(negedge clk); in_valid = 1'b0; #1;
        for (int b = 0; b < 8; b++) begin
            check_beat("e4m3", 32'h807F807F, 4'b1010, 4'b0101, 8'hFF, 1'b1, 3'd1, b == 0, b == 7);
            if (b == 7) begin
                in_valid = 1'b1; in_fmt = 3'd7;
            end
            @(negedge clk); in_valid = 1'b0; #1;
        end
        check_eq("illlast.out_valid", out_valid, 0);
        check_eq("illlast.err_fmt",   err_fmt,   1);
        @(negedge clk); #1;
        check_eq("illlast.err_clr",   err_fmt,   0);

        // E3M2 ramp with out_ready pattern 1,0,0,1
        in_valid = 1'b1; in_fmt = 3'd2; in_vec = pack_vec(3'd2, 8'h11, 8'h00, 8'h00, 1'b1);
        @(negedge clk); in_valid = 1'b0;
        beat = 0; cyc = 0;
        while (beat < 8 && cyc < 40) begin
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            #1;
            check_beat("e3m2", ramp_word(beat), (beat == 0) ? 4'b0001 : 4'b0000, 4'b0000,
                       8'h11, 1'b0, 3'd2, beat == 0, beat == 7);
            check_eq("e3m2.in_ready", in_ready, (beat == 7) && out_ready);
            if (out_ready) beat++;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check_eq("e3m2.beats", beat, 8);
        check_eq("e3m2.done",  out_valid, 0);

        // Illegal format in IDLE
        in_valid = 1'b1; in_fmt = 3'd6; in_vec = pack_vec(3'd5, 8'h33, 8'h00, 8'h00, 1'b1);
        @(negedge clk); in_valid = 1'b0; #1;
        check_eq("ill.err_fmt",   err_fmt,   1);
        check_eq("ill.out_valid", out_valid, 0);
        check_eq("ill.in_ready",  in_ready,  1);
        @(negedge clk); #1;
        check_eq("ill.err_clr",   err_fmt,   0);
        check_eq("ill.idle",      out_valid, 0);

        // Reset at beat 3, then a fresh E2M3 vector
        in_valid = 1'b1; in_fmt = 3'd5; in_vec = pack_vec(3'd5, 8'h22, 8'h00, 8'h00, 1'b1);
        @(negedge clk); in_valid = 1'b0; #1;
        repeat (3) begin
            @(negedge clk); #1;
        end
        check_beat("pre_rst", ramp_word(3), 4'b0000, 4'b0000, 8'h22, 1'b0, 3'd5, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst.out_valid", out_valid, 0);
        check_eq("midrst.out_elem",  out_elem,  0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_fmt = 3'd3; in_vec = pack_vec(3'd3, 8'h40, 8'h00, 8'h00, 1'b1);
        @(negedge clk); in_valid = 1'b0; #1;
        for (int b = 0; b < 8; b++) begin
            check_beat("e2m3", ramp_word(b), (b == 0) ? 4'b0001 : 4'b0000, 4'b0000,
                       8'h40, 1'b0, 3'd3, b == 0, b == 7);
            @(negedge clk); #1;
        end
        check_eq("e2m3.done", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
